// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake on both sides.
// Optional signed-overflow output Ovf is built when CSKIP_OVERFLOW_EN is defined.
module pipelined_carry_skip_adder #(
  parameter int WIDTH  = 16,
  parameter int BLK_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             sub,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef CSKIP_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NBLK = WIDTH / BLK_W;
  localparam int BPS  = NBLK / STAGES;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [STAGES-1:0] vi;
  logic [STAGES-1:0] ci;
  logic [WIDTH-1:0]  ai [STAGES];
  logic [WIDTH-1:0]  bi [STAGES];
  logic [WIDTH-1:0]  si [STAGES];

  logic [STAGES-1:0] cn;
  logic [WIDTH-1:0]  an [STAGES];
  logic [WIDTH-1:0]  bn [STAGES];
  logic [WIDTH-1:0]  sn [STAGES];

  logic [STAGES-1:0] adv;
  logic              chain_c;
  logic [BLK_W:0]    blk_r;
  logic              ok;

  // Ripple inside the block; the block carry-out bypasses the ripple when every bit propagates.
  function automatic logic [BLK_W:0] skip_block(input logic [BLK_W-1:0] a,
                                                input logic [BLK_W-1:0] b,
                                                input logic             cin);
    logic [BLK_W-1:0] s;
    logic             rc;
    logic             p;
    rc = cin;
    p  = 1'b1;
    s  = {BLK_W{1'b0}};
    for (int i = 0; i < BLK_W; i++) begin
      s[i] = a[i] ^ b[i] ^ rc;
      rc   = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc);
      p    = p & (a[i] ^ b[i]);
    end
    return {(p ? cin : rc), s};
  endfunction

  // Stage inputs: stage 0 takes the ports (subtract folds into ~b with carry-in 1).
  always_comb begin
    vi[0] = in_valid;
    ai[0] = operand1;
    bi[0] = sub ? ~operand2 : operand2;
    ci[0] = sub ? 1'b1 : Cin;
    si[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      vi[k] = v_q[k-1];
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      ci[k] = c_q[k-1];
      si[k] = s_q[k-1];
    end
  end

  // Each stage resolves its share of blocks; the last stage also takes any remainder blocks.
  always_comb begin
    chain_c = 1'b0;
    blk_r   = {(BLK_W+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      chain_c = ci[k];
      an[k]   = ai[k];
      bn[k]   = bi[k];
      sn[k]   = si[k];
      for (int blk = 0; blk < NBLK; blk++) begin
        if (blk >= k * BPS && (blk < (k + 1) * BPS || k == STAGES - 1)) begin
          blk_r   = skip_block(ai[k][blk*BLK_W +: BLK_W], bi[k][blk*BLK_W +: BLK_W], chain_c);
          sn[k][blk*BLK_W +: BLK_W] = blk_r[BLK_W-1:0];
          an[k][blk*BLK_W +: BLK_W] = {BLK_W{1'b0}};
          bn[k][blk*BLK_W +: BLK_W] = {BLK_W{1'b0}};
          chain_c = blk_r[BLK_W];
        end else begin
          chain_c = chain_c;
        end
      end
      cn[k] = chain_c;
    end
  end

  // Backpressure ripples from the output back toward stage 0.
  always_comb begin
    ok            = out_ready | ~v_q[STAGES-1];
    adv           = {STAGES{1'b0}};
    adv[STAGES-1] = ok;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ok     = ~v_q[k] | ok;
      adv[k] = ok;
    end
  end

  // Pipeline registers; data only loads when a valid operation moves in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= {STAGES{1'b0}};
      c_q <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
        s_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= vi[k];
          if (vi[k]) begin
            c_q[k] <= cn[k];
            a_q[k] <= an[k];
            b_q[k] <= bn[k];
            s_q[k] <= sn[k];
          end
        end
      end
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = v_q[STAGES-1];
  assign Result    = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];

`ifdef CSKIP_OVERFLOW_EN
  logic ovf_n;
  logic ovf_q;

  // Signed overflow: operand signs agree (b already inverted for subtract) but the sum sign differs.
  assign ovf_n = (ai[STAGES-1][WIDTH-1] == bi[STAGES-1][WIDTH-1]) &&
                 (sn[STAGES-1][WIDTH-1] != ai[STAGES-1][WIDTH-1]);

  // Overflow flag travels with the result out of the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[STAGES-1] && vi[STAGES-1]) begin
      ovf_q <= ovf_n;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench: directed cases plus randomized traffic against an arithmetic reference queue.
module tb_pipelined_carry_skip_adder;
  localparam int W   = 16;
  localparam int STG = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         sub;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Cout;
`ifdef CSKIP_OVERFLOW_EN
  logic         Ovf;
`endif

  int           total = 0;
  int           bad   = 0;
  logic [17:0]  expq[$];
  logic         acc;
  logic         popped;
  logic [W-1:0] last_res;
  logic         last_cout;
  logic         last_ovf;
  logic         hold_pend;
  logic [W-1:0] hold_res;
  logic         hold_cout;
  int           pushed;
  int           lat;

  always #5 clk = ~clk;

  pipelined_carry_skip_adder #(.WIDTH(W), .BLK_W(4), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .sub(sub), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Cout(Cout)
`ifdef CSKIP_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, cout, result}.
  function automatic logic [17:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic ci);
    int         sa, sb, sr;
    logic [16:0] u;
    logic        ov;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      u  = {(a >= b), a - b};
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      sr = sa + sb + int'(ci);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, u};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h8000;
      3:       v = 16'h7FFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic c, input logic r);
    logic [17:0] e;
    @(negedge clk);
    in_valid = v; operand1 = a; operand2 = b; sub = s; Cin = c; out_ready = r;
    #1;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_result", Result, hold_res);
      check("hold_cout", Cout, hold_cout);
    end
    hold_pend = out_valid && !out_ready;
    hold_res  = Result;
    hold_cout = Cout;
    popped    = out_valid && out_ready;
    if (popped) begin
      if (expq.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = expq.pop_front();
        check("result", Result, e[15:0]);
        check("cout", Cout, e[16]);
`ifdef CSKIP_OVERFLOW_EN
        check("ovf", Ovf, e[17]);
        last_ovf = Ovf;
`endif
        last_res  = Result;
        last_cout = Cout;
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      expq.push_back(ref_op(a, b, s, c));
      pushed++;
    end
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
    step(1'b1, a, b, s, c, 1'b1);
    check("single_accept", acc, 1);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      if (popped) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, STG);
  endtask

  initial begin
    int start, cyc;
    rst_n = 1'b0; in_valid = 1'b0; operand1 = '0; operand2 = '0; sub = 1'b0; Cin = 1'b0;
    out_ready = 1'b1; hold_pend = 1'b0; pushed = 0; last_res = '0; last_cout = 1'b0; last_ovf = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_cout", Cout, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);

    // Directed arithmetic
    single(16'hA0A0, 16'hA0A0, 1'b0, 1'b0);
    check("add_a0a0_res", last_res, 16'h4140);
    check("add_a0a0_cout", last_cout, 1);
    single(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    check("skip_res", last_res, 16'h0000);
    check("skip_cout", last_cout, 1);
    single(16'h0005, 16'h0007, 1'b1, 1'b1);
    check("sub_neg_res", last_res, 16'hFFFE);
    check("sub_neg_cout", last_cout, 0);
    single(16'h0007, 16'h0005, 1'b1, 1'b0);
    check("sub_pos_res", last_res, 16'h0002);
    check("sub_pos_cout", last_cout, 1);
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("ovf_case_res", last_res, 16'h8000);
`ifdef CSKIP_OVERFLOW_EN
    check("ovf_case_flag", last_ovf, 1);
`endif

    // Backpressure: two fill the pipe, the third is refused until the output drains
    step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    check("bp_acc1", acc, 1);
    step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
    check("bp_acc2", acc, 1);
    step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    check("bp_full_in_ready", in_ready, 0);
    step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    check("bp_full_in_ready2", in_ready, 0);
    step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
    check("bp_pop1", popped, 1);
    check("bp_acc3", acc, 1);
    check("bp_first", last_res, 16'h0003);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("bp_pop2", popped, 1);
    check("bp_second", last_res, 16'h0030);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("bp_pop3", popped, 1);
    check("bp_third", last_res, 16'h0007);

    // Reset with two operations in flight
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", Result, 0);
    check("midrst_in_ready", in_ready, 0);
    expq.delete();
    hold_pend = 1'b0;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      check("no_stale", out_valid, 0);
    end

    // Random traffic
    start = pushed;
    cyc   = 0;
    while ((pushed - start) < 10000 && cyc < 60000) begin
      step(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("random_count", pushed - start, 10000);
    for (int n = 0; n < 20 && expq.size() != 0; n++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    end
    check("drain_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
